// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron family: FSM encoding, spike counter
// width and the saturating adder every neuron datapath uses.
package lif_pkg;

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_e;

    localparam int SPIKE_CNT_W = 16;

    // Add two unsigned operands and clip the result at max_v.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max_v}) sat_add = max_v;
        else                   sat_add = s[31:0];
    endfunction

endpackage

// File: rtl/lif_leak_datapath.sv
// Combinational LIF update: leak, saturating current add, threshold compare.
module lif_leak_datapath
    import lif_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int THRESHOLD  = 200
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] current_i,
    output logic [WIDTH-1:0] decayed_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             fire_o
);

    localparam logic [31:0] MAX_V = (32'd1 << WIDTH) - 32'd1;

    assign decayed_o = state_i - (state_i >> LEAK_SHIFT);
    assign sum_o     = WIDTH'(sat_add(32'(decayed_o), 32'(current_i), MAX_V));
    // Threshold is compared against the clipped sum, so a saturated input still fires.
    assign fire_o    = 32'(sum_o) >= 32'(THRESHOLD);

endmodule

// File: rtl/lif_neuron_param.sv
// Parametrised leaky integrate-and-fire neuron with refractory period.
// Optional macro LIF_SPIKE_COUNT_EN adds a saturating 16-bit spike_count output.
module lif_neuron_param
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 1,
    parameter int THRESHOLD     = 200,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [WIDTH-1:0]       current,
    output logic [WIDTH-1:0]       state,
    output logic                   spike,
`ifdef LIF_SPIKE_COUNT_EN
    output logic [SPIKE_CNT_W-1:0] spike_count,
`endif
    output logic                   refractory
);

    localparam int CNT_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (REFRAC_CYCLES > 0) ? CNT_W'(REFRAC_CYCLES - 1) : '0;

    lif_state_e       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             spike_q, spike_d;

    logic [WIDTH-1:0] decayed, sum;
    logic             fire;

    lif_leak_datapath #(
        .WIDTH     (WIDTH),
        .LEAK_SHIFT(LEAK_SHIFT),
        .THRESHOLD (THRESHOLD)
    ) u_dp (
        .state_i  (state_q),
        .current_i(current),
        .decayed_o(decayed),
        .sum_o    (sum),
        .fire_o   (fire)
    );

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        spike_d = 1'b0;
        if (en) begin
            case (fsm_q)
                ST_INTEGRATE: begin
                    if (fire) begin
                        state_d = '0;
                        spike_d = 1'b1;
                        if (REFRAC_CYCLES > 0) begin
                            fsm_d = ST_REFRACTORY;
                            cnt_d = CNT_INIT;
                        end
                    end else begin
                        state_d = sum;
                    end
                end
                ST_REFRACTORY: begin
                    // Leak only; the counter reaching zero marks the last refractory edge.
                    state_d = decayed;
                    if (cnt_q == '0) fsm_d = ST_INTEGRATE;
                    else             cnt_d = cnt_q - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_INTEGRATE;
            cnt_q   <= '0;
            state_q <= '0;
            spike_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            spike_q <= spike_d;
        end
    end

    assign state      = state_q;
    assign spike      = spike_q;
    assign refractory = (fsm_q == ST_REFRACTORY);

`ifdef LIF_SPIKE_COUNT_EN
    logic [SPIKE_CNT_W-1:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = scnt_q;
        if (spike_d && (scnt_q != '1)) scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt_q <= '0;
        else        scnt_q <= scnt_d;
    end

    assign spike_count = scnt_q;
`endif

endmodule

// File: doc/lif_neuron_param.md
Name: lif_neuron_param

Overview:
- Parametrised leaky integrate-and-fire neuron; next generation of the fixed 8-bit LIF core used in the top-level wrapper.
- Adds configurable membrane width, leak rate, threshold and refractory period, plus a saturating datapath, clock enable and refractory status output.
- Sits between the input current bus (switches or upstream neuron spike) and the state/spike outputs; chainable neuron-to-neuron.

Parameters:
- WIDTH, 8, membrane potential and input current width in bits (4..16).
- LEAK_SHIFT, 1, leak per update = state >> LEAK_SHIFT (1..WIDTH-1).
- THRESHOLD, 200, firing threshold; legal range 1..2^WIDTH-1.
- REFRAC_CYCLES, 4, enabled cycles held in refractory after a spike; 0 disables refractory.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  update enable; low freezes all state.
- current  input  WIDTH  unsigned input current added each update.
- state  output  WIDTH  registered membrane potential.
- spike  output  1  registered one-cycle spike pulse.
- refractory  output  1  high while in ST_REFRACTORY.

Behaviour:
- Reset (async, rst_n=0): state=0, spike=0, refractory=0, FSM=ST_INTEGRATE, refractory counter=0. Reset mid-refractory aborts it.
- en=0: state, FSM, counter held; spike driven 0 on next edge.
- ST_INTEGRATE, en=1: decayed = state - (state >> LEAK_SHIFT); sum = decayed + current computed in WIDTH+1 bits, saturated to 2^WIDTH-1.
  - sum < THRESHOLD: state<=sum, spike<=0.
  - sum >= THRESHOLD (compare on saturated value): state<=0, spike<=1; if REFRAC_CYCLES>0 go ST_REFRACTORY with counter<=REFRAC_CYCLES-1, else stay ST_INTEGRATE.
- ST_REFRACTORY, en=1: current ignored; state<=decayed (leak only); spike<=0; counter decrements; when counter==0 on an enabled edge, return to ST_INTEGRATE (exactly REFRAC_CYCLES enabled cycles spent).
- refractory output registered, equals (FSM==ST_REFRACTORY).
- Latency: input to state/spike is one clock. Spike never high two consecutive cycles when REFRAC_CYCLES>0; with REFRAC_CYCLES=0 it may repeat every cycle.

Optional Feature:
- Macro LIF_SPIKE_COUNT_EN.
- Defined: extra output spike_count [15:0], reset 0, increments on each cycle spike is asserted, saturates at 16'hFFFF (no wrap); held when en=0.
- Undefined: port and counter absent; remaining behaviour identical.

Decomposition:
- Shared package lif_pkg: FSM enum (ST_INTEGRATE, ST_REFRACTORY), localparam SPIKE_CNT_W=16, saturating-add function sat_add used by all neuron variants.
- One natural sub-module: lif_leak_datapath (combinational decay + saturating add + threshold compare), reused by future multi-neuron arrays.

Test Plan:
- Reset: rst_n low mid-stream -> state=0, spike=0, refractory=0 asynchronously, before next clock edge.
- Defaults, en=1, current=100 from state 0 -> state 100,150,175,188,194,197,199; eighth edge: state=0, spike=1 one cycle.
- After that spike, current=100 held -> refractory=1 for 4 cycles, state stays 0, spike=0; integration resumes: state=100 on edge after refractory clears.
- Saturation: state=200-path; apply current=255 at state 199 -> sum clipped to 255, spike=1, state=0; with THRESHOLD=255 override, current=255 from 0 -> spike on first edge.
- en toggling: en=0 for 3 cycles mid-integration and mid-refractory -> state, counter, refractory frozen, spike=0; sequence resumes unchanged on en=1.
- LIF_SPIKE_COUNT_EN defined, REFRAC_CYCLES=0, THRESHOLD=1, current=1 -> spike every cycle, spike_count increments per cycle, preloaded near 16'hFFFF it holds at 16'hFFFF.
